// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle arithmetic right shifter.
// The shift amount is encoded as n = ~i_arg_B read as a signed BITS-bit value.
// A negative n gives an error, n > BITS gives an overflow, and 0 <= n <= BITS
// shifts i_arg_A right arithmetically by n bits.
// Optional macro SHIFT_SEQUENCER_STEP4_EN: shift up to 4 bits per SHIFT cycle
// instead of 1. Results and flags do not change, only the SHIFT-phase latency.
//
// Handshake: i_start acts as "valid" and !o_busy acts as "ready". A request
// is accepted on a rising edge where i_start=1 and the block is IDLE. Operands
// are sampled only on that edge. A request made while busy (including DONE)
// is dropped, not queued. o_done pulses for one cycle when the results update.
// Results and flags then hold until the next o_done. The flags are cleared
// when the next request is accepted.
module shift_sequencer #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic            o_busy,
    output logic            o_done,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
    output logic            o_overflow,
    output logic [1:0]      o_state
);

    // Counter must hold values 0..BITS inclusive.
    localparam int CW = $clog2(BITS) + 1;
    localparam logic [BITS-1:0] BITS_VAL = BITS'(BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic [BITS-1:0] work;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   step;
    logic            pend_err;
    logic            pend_ovf;
    logic [BITS-1:0] n_dec;
    logic            n_neg;
    logic            n_big;

    // Decode the shift amount from the raw operand.
    assign n_dec = ~i_arg_B;
    assign n_neg = n_dec[BITS-1];
    assign n_big = !n_neg && (n_dec > BITS_VAL);

    assign o_state = state;

    // Bits consumed per SHIFT cycle.
`ifdef SHIFT_SEQUENCER_STEP4_EN
    assign step = (cnt > CW'(4)) ? CW'(4) : cnt;
`else
    assign step = CW'(1);
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs.
    // Immediate cases (error, overflow, n == 0) enter SHIFT with a zero count.
    // They spend one cycle there, so every case has a latency of 1 + shift
    // cycles.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift while counting, publish on DONE entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work       <= '0;
            cnt        <= '0;
            pend_err   <= 1'b0;
            pend_ovf   <= 1'b0;
            o_result   <= '0;
            o_error    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (accept) begin
            work       <= i_arg_A;
            pend_err   <= n_neg;
            pend_ovf   <= n_big;
            cnt        <= (n_neg || n_big) ? '0 : n_dec[CW-1:0];
            o_error    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                work <= $signed(work) >>> step;
                cnt  <= cnt - step;
            end else begin
                o_result   <= (pend_err || pend_ovf) ? '0 : work;
                o_error    <= pend_err;
                o_overflow <= pend_ovf;
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer (BITS=32).
// Expected values come from a behavioural model of the decode and shift rules.
module tb_shift_sequencer;

    localparam int BITS = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [BITS-1:0] arg_a = '0;
    logic [BITS-1:0] arg_b = '0;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;
    logic            error;
    logic            overflow;
    logic [1:0]      state_dbg;

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] last_result = '0;
    logic            last_err = 1'b0;
    logic            last_ovf = 1'b0;

    shift_sequencer #(.BITS(BITS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_arg_A    (arg_a),
        .i_arg_B    (arg_b),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_error    (error),
        .o_overflow (overflow),
        .o_state    (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: result, flags and start-to-done latency in cycles.
    function automatic void model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                  output logic [BITS-1:0] r, output logic e,
                                  output logic o, output int lat);
        logic signed [BITS-1:0] ns;
        int n;
        ns = ~b;
        n = int'(ns);
        r = '0;
        e = 1'b0;
        o = 1'b0;
        lat = 1;
        if (n < 0) begin
            e = 1'b1;
        end else if (n > BITS) begin
            o = 1'b1;
        end else begin
            if (n == BITS) r = {BITS{a[BITS-1]}};
            else r = $signed(a) >>> n;
`ifdef SHIFT_SEQUENCER_STEP4_EN
            lat = 1 + (n + 3) / 4;
`else
            lat = 1 + n;
`endif
        end
    endfunction

    function automatic logic [BITS-1:0] enc(input int n);
        logic [BITS-1:0] v;
        v = n;
        return ~v;
    endfunction

    // Driver plus checks for one operation. An optional extra i_start pulse
    // can be sent during SHIFT (pulse_at = cycle index) and/or during DONE.
    task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input int pulse_at, input bit pulse_done, input string name);
        logic [BITS-1:0] r;
        logic [BITS-1:0] exp_r;
        logic e;
        logic o;
        int lat;
        int c;
        bit got;
        model(a, b, r, e, o, lat);
        exp_q.push_back(r);
        @(posedge clk); #1;
        arg_a = a;
        arg_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        arg_a = $urandom;
        arg_b = $urandom;
        checks++;
        if (busy !== 1'b1 || error !== 1'b0 || overflow !== 1'b0 || result !== last_result) begin
            errors++;
            $display("FAIL %s accept: busy=%b err=%b ovf=%b res=%h, required busy=1 err=0 ovf=0 res=%h",
                     name, busy, error, overflow, result, last_result);
        end
        c = 0;
        got = 0;
        while (c < 200 && !got) begin
            @(posedge clk); #1;
            start = 1'b0;
            c++;
            if (done === 1'b1) got = 1;
            else if (c == pulse_at) begin
                start = 1'b1;
                arg_a = $urandom;
                arg_b = $urandom;
            end
        end
        exp_r = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done in 200 cycles, required done after %0d", name, lat);
        end else begin
            if (c != lat) begin
                errors++;
                $display("FAIL %s latency: got %0d, required %0d", name, c, lat);
            end
            checks++;
            if (result !== exp_r || error !== e || overflow !== o) begin
                errors++;
                $display("FAIL %s result: res=%h err=%b ovf=%b, required res=%h err=%b ovf=%b",
                         name, result, error, overflow, exp_r, e, o);
            end
        end
        last_result = exp_r;
        last_err = e;
        last_ovf = o;
        if (pulse_done) begin
            start = 1'b1;
            arg_a = $urandom;
            arg_b = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: busy=%b done=%b, required busy=0 done=0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || error !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b res=%h err=%b ovf=%b, required all 0",
                     busy, done, result, error, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_result = '0;
    endtask

    task automatic test_directed();
        run_op(32'h8000_0010, 32'hFFFF_FFFC, 0, 0, "n3");
        run_op(32'h1234_5678, 32'hFFFF_FFFF, 0, 0, "n0");
        run_op(32'h8000_0000, 32'hFFFF_FFDF, 0, 0, "n32_neg");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFDF, 0, 0, "n32_pos");
        run_op(32'h1234_5678, 32'h0000_0000, 0, 0, "err");
        run_op(32'h8765_4321, 32'hFFFF_FFD7, 0, 0, "ovf");
        run_op(32'hCAFE_F00D, 32'hFFFF_FFDE, 0, 0, "n33");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, "n1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [BITS-1:0] b;
            if ($urandom_range(0, 7) == 0) b = $urandom;
            else b = enc(int'($urandom_range(0, 45)) - 4);
            run_op($urandom, b, 0, 0, "random");
        end
    endtask

    task automatic test_busy_ignore();
        run_op(32'h8000_1234, enc(20), 5, 1, "busy_ignore");
        run_op(32'h0F0F_0F0F, enc(6), 3, 1, "busy_ignore2");
    endtask

    task automatic test_hold();
        run_op(32'hA5A5_0000, enc(4), 0, 0, "hold_setup");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            arg_a = $urandom;
            arg_b = $urandom;
            checks++;
            if (result !== last_result || error !== last_err || overflow !== last_ovf || done !== 1'b0) begin
                errors++;
                $display("FAIL hold: res=%h err=%b ovf=%b done=%b, required res=%h err=%b ovf=%b done=0",
                         result, error, overflow, done, last_result, last_err, last_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 0;
        @(posedge clk); #1;
        arg_a = 32'h8123_4567;
        arg_b = enc(20);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) saw_done = 1;
            if (c == 5) start = 1'b1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || error !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b res=%h err=%b ovf=%b, required all 0",
                     busy, done, result, error, overflow);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_done: done pulsed, required none");
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_result = '0;
        last_err = 1'b0;
        last_ovf = 1'b0;
        exp_q.delete();
        run_op(32'h8000_0010, 32'hFFFF_FFFC, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
